flash_access_arbiter: RTL and testbench

FLASH_ACCESS_ARBITER -- requirements
Module: flash_access_arbiter

---
 rtl/flash_access_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_flash_access_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_access_arbiter.sv
// ---------------------------------------------------------------------------
// flash_access_arbiter
//   Arbitrates two requesters onto one SPI byte engine and sequences the
//   serial-flash command set: READ (0x03), WREN (0x06) + PROG (0x02) and
//   RDSR (0x05) status polling until the write-in-progress bit clears or
//   the poll budget runs out.
//
// Parameters
//   POLL_MAX  maximum status polls per write before reporting an error
//   CS_GAP    clk cycles chip select is held high between commands
//
// Ports
//   clk, reset                      system clock, synchronous active-high reset
//   i_pN_req/rw/addr/wdata          requester N transaction (held until ack)
//   o_pN_ack/rdata/err              requester N completion pulse and results
//   o_eng_start/txbyte              start one byte transfer on the SPI engine
//   o_eng_cs_n                      flash chip select, active low
//   i_eng_done/rxbyte               byte transfer complete and received byte
//   o_busy                          high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module flash_access_arbiter #(
    parameter logic [15:0] POLL_MAX = 16'd48000,
    parameter logic [3:0]  CS_GAP   = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_p0_req,
    input  logic        i_p0_rw,
    input  logic [23:0] i_p0_addr,
    input  logic [7:0]  i_p0_wdata,
    output logic        o_p0_ack,
    output logic [7:0]  o_p0_rdata,
    output logic        o_p0_err,
    input  logic        i_p1_req,
    input  logic        i_p1_rw,
    input  logic [23:0] i_p1_addr,
    input  logic [7:0]  i_p1_wdata,
    output logic        o_p1_ack,
    output logic [7:0]  o_p1_rdata,
    output logic        o_p1_err,
    output logic        o_eng_start,
    output logic [7:0]  o_eng_txbyte,
    output logic        o_eng_cs_n,
    input  logic        i_eng_done,
    input  logic [7:0]  i_eng_rxbyte,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WREN = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_PROG = 3'd4;
    localparam logic [2:0] S_POLL = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    // A zero gap would merge two commands into one chip-select window.
    localparam logic [3:0] GAP_LAST = (CS_GAP == 4'd0) ? 4'd0 : CS_GAP - 4'd1;

    logic [2:0]  state_q, state_d;
    logic [2:0]  gap_ret_q, gap_ret_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        wait_q, wait_d;
    logic        gnt_q, gnt_d;
    logic        prefer_q, prefer_d;
    logic        rw_q, rw_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  p0_rdata_q, p0_rdata_d;
    logic [7:0]  p1_rdata_q, p1_rdata_d;

    logic        is_cmd;
    logic [7:0]  cmd_byte;
    logic [2:0]  last_idx;
    logic        eng_start;
    logic [7:0]  eng_txbyte;
    logic        poll_limit;

    assign is_cmd = (state_q == S_READ) || (state_q == S_WREN) ||
                    (state_q == S_PROG) || (state_q == S_POLL);

    assign poll_limit = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_MAX};

    // Byte to shift for the current command and position.
    always_comb begin
        cmd_byte = 8'h00;
        last_idx = 3'd0;
        case (state_q)
            S_READ: begin
                last_idx = 3'd4;
                case (idx_q)
                    3'd0:    cmd_byte = 8'h03;
                    3'd1:    cmd_byte = addr_q[23:16];
                    3'd2:    cmd_byte = addr_q[15:8];
                    3'd3:    cmd_byte = addr_q[7:0];
                    default: cmd_byte = 8'h00;
                endcase
            end
            S_WREN: begin
                last_idx = 3'd0;
                cmd_byte = 8'h06;
            end
            S_PROG: begin
                last_idx = 3'd4;
                case (idx_q)
                    3'd0:    cmd_byte = 8'h02;
                    3'd1:    cmd_byte = addr_q[23:16];
                    3'd2:    cmd_byte = addr_q[15:8];
                    3'd3:    cmd_byte = addr_q[7:0];
                    default: cmd_byte = wdata_q;
                endcase
            end
            S_POLL: begin
                last_idx = 3'd1;
                cmd_byte = (idx_q == 3'd0) ? 8'h05 : 8'h00;
            end
            default: begin
                cmd_byte = 8'h00;
                last_idx = 3'd0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gap_ret_d  = gap_ret_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        gnt_d      = gnt_q;
        prefer_d   = prefer_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        poll_cnt_d = poll_cnt_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        eng_start  = 1'b0;
        eng_txbyte = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (i_p0_req || i_p1_req) begin
                    gnt_d      = (i_p0_req && i_p1_req) ? prefer_q : i_p1_req;
                    prefer_d   = ~gnt_d;
                    rw_d       = gnt_d ? i_p1_rw    : i_p0_rw;
                    addr_d     = gnt_d ? i_p1_addr  : i_p0_addr;
                    wdata_d    = gnt_d ? i_p1_wdata : i_p0_wdata;
                    idx_d      = 3'd0;
                    wait_d     = 1'b0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    state_d    = rw_d ? S_READ : S_WREN;
                end
            end

            S_READ, S_WREN, S_PROG, S_POLL: begin
                if (!wait_q) begin
                    eng_start  = 1'b1;
                    eng_txbyte = cmd_byte;
                    wait_d     = 1'b1;
                end else if (i_eng_done) begin
                    wait_d = 1'b0;
                    if (idx_q != last_idx) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d     = 3'd0;
                        gap_cnt_d = '0;
                        case (state_q)
                            S_READ: begin
                                // Publish read data now so it is valid in the ack cycle.
                                if (gnt_q) p1_rdata_d = i_eng_rxbyte;
                                else       p0_rdata_d = i_eng_rxbyte;
                                state_d = S_RESP;
                            end
                            S_WREN: begin
                                gap_ret_d = S_PROG;
                                state_d   = S_GAP;
                            end
                            S_PROG: begin
                                gap_ret_d = S_POLL;
                                state_d   = S_GAP;
                            end
                            default: begin
                                poll_cnt_d = poll_cnt_q + 16'd1;
                                if (!i_eng_rxbyte[0]) begin
                                    err_d   = 1'b0;
                                    state_d = S_RESP;
                                end else if (poll_limit) begin
                                    err_d   = 1'b1;
                                    state_d = S_RESP;
                                end else begin
                                    gap_ret_d = S_POLL;
                                    state_d   = S_GAP;
                                end
                            end
                        endcase
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = gap_ret_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_ret_q  <= S_IDLE;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            wait_q     <= 1'b0;
            gnt_q      <= 1'b0;
            prefer_q   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_ret_q  <= gap_ret_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            gnt_q      <= gnt_d;
            prefer_q   <= prefer_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            poll_cnt_q <= poll_cnt_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign o_eng_start  = eng_start;
    assign o_eng_txbyte = eng_txbyte;
    assign o_eng_cs_n   = ~is_cmd;
    assign o_busy       = (state_q != S_IDLE);
    assign o_p0_ack     = (state_q == S_RESP) && !gnt_q;
    assign o_p1_ack     = (state_q == S_RESP) &&  gnt_q;
    assign o_p0_err     = o_p0_ack && err_q;
    assign o_p1_err     = o_p1_ack && err_q;
    assign o_p0_rdata   = p0_rdata_q;
    assign o_p1_rdata   = p1_rdata_q;

endmodule

// File: tb/tb_flash_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flash_access_arbiter
//   Directed bench for flash_access_arbiter (POLL_MAX=3, CS_GAP=2). A small
//   SPI engine model answers each start with a done two cycles later and
//   logs transmitted bytes and chip-select windows.
// ---------------------------------------------------------------------------
module tb_flash_access_arbiter;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [23:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        eng_start, eng_cs_n, eng_done, busy;
    logic [7:0]  eng_txbyte, eng_rxbyte;

    always #5 clk = ~clk;

    flash_access_arbiter #(.POLL_MAX(16'd3), .CS_GAP(4'd2)) dut (
        .clk(clk), .reset(reset),
        .i_p0_req(p0_req), .i_p0_rw(p0_rw), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_ack(p0_ack), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_rw(p1_rw), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .o_p1_ack(p1_ack), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_eng_start(eng_start), .o_eng_txbyte(eng_txbyte), .o_eng_cs_n(eng_cs_n),
        .i_eng_done(eng_done), .i_eng_rxbyte(eng_rxbyte), .o_busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model state (written only by the engine process, except the
    // environment knobs which only the main process writes).
    logic [7:0] tx_q[$];
    int         gap_q[$];
    int         seg_cnt    = 0;
    int         polls_seen = 0;
    int         proto_err  = 0;
    int         ack_total  = 0;
    int         stray_seen = 0;
    int         stray_req  = 0;
    int         poll_base  = 0;
    int         nbusy      = 0;
    logic [7:0] busy_val   = 8'h01;
    logic [7:0] ready_val  = 8'h00;
    logic [7:0] rd_val     = 8'h00;

    initial begin
        bit         eng_busy = 0;
        int         cnt = 0;
        int         seg_pos = 0;
        int         run = 0;
        logic       prev_cs = 1'b1;
        logic [7:0] seg_first = 8'h00;
        logic [7:0] rx_pend = 8'h00;
        eng_done   = 1'b0;
        eng_rxbyte = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            eng_done = 1'b0;
            if (reset) begin
                eng_busy = 0;
                cnt      = 0;
            end else if (eng_busy) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done   = 1'b1;
                    eng_rxbyte = rx_pend;
                    eng_busy   = 0;
                end
            end else if (stray_seen != stray_req) begin
                stray_seen++;
                eng_done   = 1'b1;
                eng_rxbyte = 8'h00;
            end
            if (eng_cs_n) begin
                run++;
                seg_pos = 0;
            end else if (prev_cs) begin
                gap_q.push_back(run);
                run = 0;
                seg_cnt++;
            end
            prev_cs = eng_cs_n;
            if (eng_start) begin
                if (eng_busy || eng_cs_n) proto_err++;
                tx_q.push_back(eng_txbyte);
                if (seg_pos == 0) seg_first = eng_txbyte;
                if (seg_first == 8'h05 && seg_pos == 1) begin
                    rx_pend = ((polls_seen - poll_base) < nbusy) ? busy_val : ready_val;
                    polls_seen++;
                end else if (seg_first == 8'h03 && seg_pos == 4) begin
                    rx_pend = rd_val;
                end else begin
                    rx_pend = 8'hEE;
                end
                seg_pos++;
                eng_busy = 1;
                cnt      = 2;
            end
            if (p0_ack) ack_total++;
            if (p1_ack) ack_total++;
            if (p0_ack && p1_ack) proto_err++;
            if ((p0_err && !p0_ack) || (p1_err && !p1_ack)) proto_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        port;
        logic        rw;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        int          nbusy;
        logic [7:0]  busy_v;
        logic [7:0]  ready_v;
        logic        drop;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_polls;
    } vec_t;

    task automatic wait_ack(output int port, output logic [7:0] rd, output logic er);
        port = -1;
        rd   = 8'h00;
        er   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (p0_ack) begin port = 0; rd = p0_rdata; er = p0_err; break; end
            if (p1_ack) begin port = 1; rd = p1_rdata; er = p1_err; break; end
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [7:0] exp_b[32];
        int         n = 0;
        int         mism = 0;
        int         gmism = 0;
        int         tbase = tx_q.size();
        int         gbase = gap_q.size();
        int         sbase = seg_cnt;
        int         pbase = polls_seen;
        int         perr  = proto_err;
        int         port;
        int         segs;
        logic [7:0] rd;
        logic       er;
        bit         dropped = 0;

        if (v.rw) begin
            exp_b[0] = 8'h03; exp_b[1] = v.addr[23:16]; exp_b[2] = v.addr[15:8];
            exp_b[3] = v.addr[7:0]; exp_b[4] = 8'h00; n = 5;
            segs = 1;
        end else begin
            exp_b[0] = 8'h06; exp_b[1] = 8'h02; exp_b[2] = v.addr[23:16];
            exp_b[3] = v.addr[15:8]; exp_b[4] = v.addr[7:0]; exp_b[5] = v.wdata; n = 6;
            for (int k = 0; k < v.exp_polls; k++) begin
                exp_b[n] = 8'h05; exp_b[n+1] = 8'h00; n += 2;
            end
            segs = 2 + v.exp_polls;
        end

        rd_val = v.rd; nbusy = v.nbusy; busy_val = v.busy_v; ready_val = v.ready_v;
        poll_base = polls_seen;
        if (v.port) begin
            p1_rw = v.rw; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1'b1;
        end else begin
            p0_rw = v.rw; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1'b1;
        end

        port = -1; rd = 8'h00; er = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (p0_ack) begin port = 0; rd = p0_rdata; er = p0_err; break; end
            if (p1_ack) begin port = 1; rd = p1_rdata; er = p1_err; break; end
            // Drop the request and scramble inputs right after the grant.
            if (v.drop && busy && !dropped) begin
                dropped = 1;
                if (v.port) begin
                    p1_req = 1'b0; p1_rw = ~p1_rw; p1_addr = ~p1_addr; p1_wdata = ~p1_wdata;
                end else begin
                    p0_req = 1'b0; p0_rw = ~p0_rw; p0_addr = ~p0_addr; p0_wdata = ~p0_wdata;
                end
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_busy_after_resp", id), busy, 0);
        check($sformatf("v%0d_ack_port", id), port, v.port);
        check($sformatf("v%0d_rdata", id), rd, v.exp_rdata);
        check($sformatf("v%0d_err", id), er, v.exp_err);
        check($sformatf("v%0d_txcount", id), tx_q.size() - tbase, n);
        for (int k = 0; k < n && (tbase + k) < tx_q.size(); k++)
            if (tx_q[tbase + k] !== exp_b[k]) mism++;
        check($sformatf("v%0d_txbytes_mismatches", id), mism, 0);
        check($sformatf("v%0d_cs_windows", id), seg_cnt - sbase, segs);
        for (int k = 1; k < segs && (gbase + k) < gap_q.size(); k++)
            if (gap_q[gbase + k] != GAP) gmism++;
        check($sformatf("v%0d_cs_gap_mismatches", id), gmism, 0);
        check($sformatf("v%0d_polls", id), polls_seen - pbase, v.exp_polls);
        check($sformatf("v%0d_protocol", id), proto_err - perr, 0);
    endtask

    initial begin
        vec_t       vecs[7];
        int         port;
        logic [7:0] rd;
        logic       er;
        int         tbase;
        int         ackb;
        int         mism;
        logic [7:0] eb[5];

        vecs[0] = '{1'b0, 1'b1, 24'h012345, 8'h00, 8'hA5, 0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 24'h000010, 8'h5A, 8'h00, 2, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 3};
        vecs[2] = '{1'b0, 1'b0, 24'hABCDEF, 8'h3C, 8'h00, 5, 8'h03, 8'h00, 1'b0, 8'hA5, 1'b1, 3};
        vecs[3] = '{1'b1, 1'b1, 24'hFFFFFF, 8'h00, 8'h5C, 0, 8'h00, 8'h00, 1'b1, 8'h5C, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 24'h800001, 8'hFF, 8'h00, 0, 8'h01, 8'hFE, 1'b1, 8'hA5, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 24'h00ABCD, 8'h11, 8'h00, 1, 8'hFF, 8'h00, 1'b0, 8'h5C, 1'b0, 2};
        vecs[6] = '{1'b0, 1'b1, 24'h00FF00, 8'h00, 8'h3C, 0, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, 0};

        reset = 1'b1;
        p0_req = 1'b0; p0_rw = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_rw = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs_n", eng_cs_n, 1);
        check("rst_start", eng_start, 0);
        check("rst_txbyte", eng_txbyte, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Stray done while idle must be ignored.
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_no_start", eng_start, 0);

        // Last grant went to p0, so a tie now goes to p1.
        rd_val = 8'h42;
        p0_rw = 1'b1; p0_addr = 24'h111111; p1_rw = 1'b1; p1_addr = 24'h222222;
        p0_req = 1'b1; p1_req = 1'b1;
        wait_ack(port, rd, er);
        p1_req = 1'b0;
        check("rr_tie_first", port, 1);
        check("rr_tie_first_rdata", rd, 8'h42);
        wait_ack(port, rd, er);
        p0_req = 1'b0;
        check("rr_tie_second", port, 0);
        check("rr_tie_second_rdata", rd, 8'h42);
        repeat (2) @(negedge clk);

        // Reset while the third PROG byte is on the wire.
        p0_rw = 1'b0; p0_addr = 24'h123456; p0_wdata = 8'h77; nbusy = 0;
        tbase = tx_q.size();
        p0_req = 1'b1;
        for (int c = 0; c < 500 && tx_q.size() < tbase + 4; c++) @(negedge clk);
        check("rst_mid_third_prog_byte", (tx_q.size() > tbase + 3) ? tx_q[tbase + 3] : 8'hFF, 8'h34);
        reset = 1'b1;
        p0_req = 1'b0;
        ackb = ack_total;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_cs_n", eng_cs_n, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_start", eng_start, 0);
        check("rst_mid_rdata", {p0_rdata, p1_rdata}, 0);
        repeat (20) @(negedge clk);
        check("rst_mid_no_ack", ack_total - ackb, 0);
        check("rst_mid_no_more_bytes", tx_q.size() - tbase, 4);

        // After reset p0 wins ties; with both held high grants alternate.
        rd_val = 8'h96;
        p0_rw = 1'b1; p0_addr = 24'h0A0B0C; p1_rw = 1'b1; p1_addr = 24'h0D0E0F;
        tbase = tx_q.size();
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(port, rd, er);
            if (i == 3) begin p0_req = 1'b0; p1_req = 1'b0; end
            check($sformatf("alt%0d_port", i), port, i % 2);
            check($sformatf("alt%0d_rdata", i), rd, 8'h96);
            @(negedge clk);
            check($sformatf("alt%0d_no_grant_in_resp", i), busy, 0);
        end
        check("alt_txcount", tx_q.size() - tbase, 20);
        mism = 0;
        for (int i = 0; i < 4; i++) begin
            eb[0] = 8'h03; eb[1] = (i % 2) ? 8'h0D : 8'h0A; eb[2] = (i % 2) ? 8'h0E : 8'h0B;
            eb[3] = (i % 2) ? 8'h0F : 8'h0C; eb[4] = 8'h00;
            for (int k = 0; k < 5 && (tbase + i * 5 + k) < tx_q.size(); k++)
                if (tx_q[tbase + i * 5 + k] !== eb[k]) mism++;
        end
        check("alt_txbytes_mismatches", mism, 0);
        check("final_protocol", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
